// File: rtl/lc3_regfile_cc_if.sv
// Register-file / condition-code port bundle between the LC-3 datapath control and the regfile.
// Signal names follow the datapath naming used throughout the LC-3 microarchitecture.
interface lc3_regfile_cc_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3
);
  logic              LD_REG;
  logic [ADDR_W-1:0] DR;
  logic [ADDR_W-1:0] SR1;
  logic [ADDR_W-1:0] SR2;
  logic [WIDTH-1:0]  BUS;
  logic [WIDTH-1:0]  SR1OUT;
  logic [WIDTH-1:0]  SR2OUT;
  logic              LD_CC;
  logic              LD_BEN;
  logic [2:0]        IR_NZP;
  logic              N;
  logic              Z;
  logic              P;
  logic              BEN;

  modport master (
    output LD_REG, DR, SR1, SR2, BUS, LD_CC, LD_BEN, IR_NZP,
    input  SR1OUT, SR2OUT, N, Z, P, BEN
  );

  modport slave (
    input  LD_REG, DR, SR1, SR2, BUS, LD_CC, LD_BEN, IR_NZP,
    output SR1OUT, SR2OUT, N, Z, P, BEN
  );
endinterface

// File: rtl/lc3_regfile_cc.sv
// LC-3 general-purpose register file (R0-R7) with N/Z/P condition codes and branch-enable latch.
// Two combinational read ports, one write port; no write-to-read bypass.
module lc3_regfile_cc #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  lc3_regfile_cc_if.slave   rf
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs [NREG];
  logic [2:0]       nzp_q;
  logic             ben_q;
  logic [2:0]       nzp_c;
  logic             ben_c;

  // Register storage; R0 is an ordinary writable register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else if (rf.LD_REG) begin
      regs[rf.DR] <= rf.BUS;
    end
  end

  assign rf.SR1OUT = regs[rf.SR1];
  assign rf.SR2OUT = regs[rf.SR2];

  // Flag decode from the bus and branch-enable from the pre-edge flags.
  always_comb begin
    nzp_c = 3'b010;
    ben_c = 1'b0;
    nzp_c = {rf.BUS[WIDTH-1], (rf.BUS == '0), (~rf.BUS[WIDTH-1] & (rf.BUS != '0))};
    ben_c = |(rf.IR_NZP & nzp_q);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      nzp_q <= 3'b010;
      ben_q <= 1'b0;
    end else begin
      if (rf.LD_CC) begin
        nzp_q <= nzp_c;
      end
      if (rf.LD_BEN) begin
        ben_q <= ben_c;
      end
    end
  end

  assign rf.N   = nzp_q[2];
  assign rf.Z   = nzp_q[1];
  assign rf.P   = nzp_q[0];
  assign rf.BEN = ben_q;

endmodule

// File: tb/tb_lc3_regfile_cc.sv
// Directed bench for lc3_regfile_cc: write/read sweep, flag/BEN vector table, and
// hand sequences for same-cycle read-of-DR, asynchronous reset and write-disable hold.
module tb_lc3_regfile_cc;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [15:0] mdl [8];

  lc3_regfile_cc_if #(.WIDTH(16), .ADDR_W(3)) rf ();

  lc3_regfile_cc #(.WIDTH(16), .ADDR_W(3)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .rf    (rf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        ld_reg;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [15:0] bus;
    logic        ld_cc;
    logic        ld_ben;
    logic [2:0]  ir_nzp;
    logic [15:0] e_sr1;
    logic [15:0] e_sr2;
    logic [2:0]  e_nzp;
    logic        e_ben;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] nzp_now();
    return 16'({rf.N, rf.Z, rf.P});
  endfunction

  task automatic idle();
    rf.LD_REG = 1'b0; rf.LD_CC = 1'b0; rf.LD_BEN = 1'b0;
    rf.DR = 3'd0; rf.BUS = 16'h0000; rf.IR_NZP = 3'b000;
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rf.SR1 = 3'd0; rf.SR2 = 3'd0;
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state
    clk_step();
    clk_step();
    for (int i = 0; i < 8; i++) begin
      rf.SR1 = 3'(i); rf.SR2 = 3'(7 - i);
      #1;
      chk("reset_sr1", rf.SR1OUT, 16'h0000);
      chk("reset_sr2", rf.SR2OUT, 16'h0000);
    end
    chk("reset_nzp", nzp_now(), 16'h0002);
    chk("reset_ben", 16'(rf.BEN), 16'h0000);
    rst_n = 1'b1;

    // Write sweep R0..R7, unwritten targets read 0 before their edge
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      rf.LD_REG = 1'b1; rf.DR = 3'(i); rf.BUS = 16'(16'h1111 * (i + 1));
      rf.SR1 = 3'(i); rf.SR2 = 3'((i + 1) % 8);
      #1;
      chk("wr_pre_sr1", rf.SR1OUT, 16'h0000);
      clk_step();
      mdl[i] = 16'(16'h1111 * (i + 1));
      chk("wr_post_sr1", rf.SR1OUT, mdl[i]);
      chk("wr_post_sr2", rf.SR2OUT, mdl[(i + 1) % 8]);
    end
    idle();
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        rf.SR1 = 3'(a); rf.SR2 = 3'(b);
        #1;
        chk("pair_sr1", rf.SR1OUT, mdl[a]);
        chk("pair_sr2", rf.SR2OUT, mdl[b]);
      end
    end

    // Read of DR in the write cycle returns the old value
    rf.LD_REG = 1'b1; rf.DR = 3'd3; rf.BUS = 16'h0005;
    clk_step();
    rf.DR = 3'd3; rf.SR1 = 3'd3; rf.BUS = 16'h00AA;
    #1;
    chk("rdw_pre", rf.SR1OUT, 16'h0005);
    clk_step();
    chk("rdw_post", rf.SR1OUT, 16'h00AA);
    idle();

    // Flag / BEN / simultaneous-load table (checked after the edge)
    //          ld_reg dr    sr1   sr2   bus       ld_cc ld_ben ir      e_sr1     e_sr2     e_nzp   e_ben
    vt[0]  = '{1'b0, 3'd0, 3'd7, 3'd0, 16'h8000, 1'b1, 1'b0, 3'b000, 16'h8888, 16'h1111, 3'b100, 1'b0};
    vt[1]  = '{1'b0, 3'd0, 3'd1, 3'd2, 16'h0000, 1'b1, 1'b1, 3'b100, 16'h2222, 16'h3333, 3'b010, 1'b1};
    vt[2]  = '{1'b0, 3'd0, 3'd1, 3'd2, 16'h7FFF, 1'b1, 1'b1, 3'b100, 16'h2222, 16'h3333, 3'b001, 1'b0};
    vt[3]  = '{1'b0, 3'd0, 3'd4, 3'd5, 16'hFFFF, 1'b0, 1'b1, 3'b011, 16'h5555, 16'h6666, 3'b001, 1'b1};
    vt[4]  = '{1'b0, 3'd0, 3'd4, 3'd5, 16'h0000, 1'b1, 1'b1, 3'b001, 16'h5555, 16'h6666, 3'b010, 1'b1};
    vt[5]  = '{1'b0, 3'd0, 3'd4, 3'd5, 16'h0000, 1'b0, 1'b1, 3'b001, 16'h5555, 16'h6666, 3'b010, 1'b0};
    vt[6]  = '{1'b0, 3'd0, 3'd4, 3'd5, 16'h0000, 1'b0, 1'b1, 3'b010, 16'h5555, 16'h6666, 3'b010, 1'b1};
    vt[7]  = '{1'b0, 3'd0, 3'd4, 3'd5, 16'h1234, 1'b0, 1'b0, 3'b000, 16'h5555, 16'h6666, 3'b010, 1'b1};
    vt[8]  = '{1'b1, 3'd3, 3'd3, 3'd3, 16'h00BB, 1'b1, 1'b0, 3'b000, 16'h00BB, 16'h00BB, 3'b001, 1'b1};
    vt[9]  = '{1'b1, 3'd0, 3'd0, 3'd4, 16'hFFFF, 1'b1, 1'b0, 3'b000, 16'hFFFF, 16'h5555, 3'b100, 1'b1};
    vt[10] = '{1'b0, 3'd0, 3'd0, 3'd3, 16'h1234, 1'b0, 1'b0, 3'b000, 16'hFFFF, 16'h00BB, 3'b100, 1'b1};
    vt[11] = '{1'b1, 3'd7, 3'd7, 3'd6, 16'h0001, 1'b1, 1'b0, 3'b000, 16'h0001, 16'h7777, 3'b001, 1'b1};
    for (int k = 0; k < 12; k++) begin
      rf.LD_REG = vt[k].ld_reg; rf.DR = vt[k].dr; rf.SR1 = vt[k].sr1; rf.SR2 = vt[k].sr2;
      rf.BUS = vt[k].bus; rf.LD_CC = vt[k].ld_cc; rf.LD_BEN = vt[k].ld_ben; rf.IR_NZP = vt[k].ir_nzp;
      clk_step();
      chk($sformatf("vec%0d_sr1", k), rf.SR1OUT, vt[k].e_sr1);
      chk($sformatf("vec%0d_sr2", k), rf.SR2OUT, vt[k].e_sr2);
      chk($sformatf("vec%0d_nzp", k), nzp_now(), 16'(vt[k].e_nzp));
      chk($sformatf("vec%0d_ben", k), 16'(rf.BEN), 16'(vt[k].e_ben));
    end
    idle();

    // Asynchronous reset between edges, with a write pending
    rf.LD_REG = 1'b1; rf.DR = 3'd5; rf.BUS = 16'hBEEF; rf.SR1 = 3'd5; rf.SR2 = 3'd7;
    clk_step();
    chk("arst_pre_r5", rf.SR1OUT, 16'hBEEF);
    rf.BUS = 16'h1234;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sr1", rf.SR1OUT, 16'h0000);
    chk("arst_sr2", rf.SR2OUT, 16'h0000);
    chk("arst_ben", 16'(rf.BEN), 16'h0000);
    chk("arst_nzp", nzp_now(), 16'h0002);
    clk_step();
    chk("arst_discard", rf.SR1OUT, 16'h0000);
    rst_n = 1'b1;
    clk_step();
    chk("first_write", rf.SR1OUT, 16'h1234);
    idle();

    // Load known values, then hold with LD_REG low for 50 cycles
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      rf.LD_REG = 1'b1; rf.DR = 3'(i); rf.BUS = 16'(16'h1000 + 16'h0101 * i);
      clk_step();
      mdl[i] = 16'(16'h1000 + 16'h0101 * i);
    end
    idle();
    for (int c = 0; c < 50; c++) begin
      logic [2:0] s;
      s = 3'($urandom_range(0, 7));
      rf.DR = 3'($urandom_range(0, 7)); rf.BUS = 16'($urandom);
      rf.SR1 = s; rf.SR2 = s;
      clk_step();
      chk("hold_sr1", rf.SR1OUT, mdl[s]);
      chk("hold_sr2", rf.SR2OUT, mdl[s]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
